control_sequencer: RTL and testbench

Hardwired control unit for the Mini-SRC datapath. It steps each instruction through fetch and execute T-states and drives the register-select strobes (Gra, Grb, Grc, Rin, Rout, BAout) consumed by the register select/encode logic. It also drives every other datapath load/drive strobe and the ALU opcode. It waits on a memory-ready handshake for all memory reads and writes.

---
 rtl/control_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini-SRC control unit.
// Steps each instruction through fetch (T0..T2) and execute (T3..T7) states. It drives the
// register select/encode strobes, the datapath load/drive strobes, memory Read/Write and the
// ALU function code. It stalls in T1, in T6 (ld) and in T7 (st) until mem_ready is high.
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   run_in                 start/continue, sampled only in T0
//   opcode[4:0]            IR[31:27], stable from T3 onward
//   con_ff                 branch condition flag, used in T6 of br
//   mem_ready              memory completed the current Read/Write
//   Gra..BAout             register select/encode strobes
//   PCout..LOin            datapath strobes
//   Read, Write            memory request
//   alu_op[4:0]            ALU function (opcode, or ADD for address/PC arithmetic)
//   run_out                low only in HALT
//   state[3:0]             current state (T0..T7 = 0..7, HALT = 8)
//
// Build option: define MULDIV_EN to execute mul/div. When it is undefined, mul/div run as nop
// and HIin/LOin stay 0.

module control_sequencer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       run_in,
   input  logic [4:0] opcode,
   input  logic       con_ff,
   input  logic       mem_ready,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       BAout,
   output logic       PCout,
   output logic       PCin,
   output logic       IncPC,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       IRin,
   output logic       Yin,
   output logic       Zin,
   output logic       Zlowout,
   output logic       Zhighout,
   output logic       Cout,
   output logic       CONin,
   output logic       HIin,
   output logic       LOin,
   output logic       Read,
   output logic       Write,
   output logic [4:0] alu_op,
   output logic       run_out,
   output logic [3:0] state
);

   localparam logic [4:0] OpLd   = 5'b00000;
   localparam logic [4:0] OpLdi  = 5'b00001;
   localparam logic [4:0] OpSt   = 5'b00010;
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpOr   = 5'b01011;
   localparam logic [4:0] OpAddi = 5'b01100;
   localparam logic [4:0] OpOri  = 5'b01110;
   localparam logic [4:0] OpBr   = 5'b10011;
   localparam logic [4:0] OpJr   = 5'b10100;
   localparam logic [4:0] OpHalt = 5'b11011;
`ifdef MULDIV_EN
   localparam logic [4:0] OpMul  = 5'b01111;
   localparam logic [4:0] OpDiv  = 5'b10000;
`endif

   typedef enum logic [3:0] {
      StT0   = 4'd0,
      StT1   = 4'd1,
      StT2   = 4'd2,
      StT3   = 4'd3,
      StT4   = 4'd4,
      StT5   = 4'd5,
      StT6   = 4'd6,
      StT7   = 4'd7,
      StHalt = 4'd8
   } state_e;

   state_e state_q, state_d;

   logic is_rfmt, is_ifmt, is_ld, is_ldi, is_st, is_br, is_jr, is_halt;
`ifdef MULDIV_EN
   logic is_muldiv;
   assign is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
`endif

   assign is_rfmt = (opcode >= OpAdd) && (opcode <= OpOr);
   assign is_ifmt = (opcode >= OpAddi) && (opcode <= OpOri);
   assign is_ld   = (opcode == OpLd);
   assign is_ldi  = (opcode == OpLdi);
   assign is_st   = (opcode == OpSt);
   assign is_br   = (opcode == OpBr);
   assign is_jr   = (opcode == OpJr);
   assign is_halt = (opcode == OpHalt);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StT0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

   always_comb begin
      state_d  = state_q;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      Rin      = 1'b0;
      Rout     = 1'b0;
      BAout    = 1'b0;
      PCout    = 1'b0;
      PCin     = 1'b0;
      IncPC    = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      Cout     = 1'b0;
      CONin    = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Read     = 1'b0;
      Write    = 1'b0;
      alu_op   = 5'b00000;
      run_out  = 1'b1;

      unique case (state_q)
         StT0: begin
            // Fetch strobes only in the cycle that actually starts an instruction, so an idle
            // T0 (and T0 held in reset) drives nothing onto the datapath.
            if (run_in && reset_n) begin
               PCout  = 1'b1;
               MARin  = 1'b1;
               IncPC  = 1'b1;
               Zin    = 1'b1;
               alu_op = OpAdd;
            end
            if (run_in) state_d = StT1;
         end
         StT1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) state_d = StT2;
         end
         StT2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = StT3;
         end
         StT3: begin
`ifdef MULDIV_EN
            if (is_muldiv) begin
               Gra     = 1'b1;
               Rout    = 1'b1;
               Yin     = 1'b1;
               state_d = StT4;
            end else
`endif
            if (is_rfmt || is_ifmt) begin
               Grb     = 1'b1;
               Rout    = 1'b1;
               Yin     = 1'b1;
               state_d = StT4;
            end else if (is_ldi || is_ld || is_st) begin
               Grb     = 1'b1;
               BAout   = 1'b1;
               Yin     = 1'b1;
               state_d = StT4;
            end else if (is_br) begin
               Gra     = 1'b1;
               Rout    = 1'b1;
               CONin   = 1'b1;
               state_d = StT4;
            end else if (is_jr) begin
               Gra     = 1'b1;
               Rout    = 1'b1;
               PCin    = 1'b1;
               state_d = StT0;
            end else if (is_halt) begin
               state_d = StHalt;
            end else begin
               state_d = StT0;  // nop and every undefined opcode
            end
         end
         StT4: begin
            state_d = StT5;
`ifdef MULDIV_EN
            if (is_muldiv) begin
               Grb    = 1'b1;
               Rout   = 1'b1;
               Zin    = 1'b1;
               alu_op = opcode;
            end else
`endif
            if (is_rfmt) begin
               Grc    = 1'b1;
               Rout   = 1'b1;
               Zin    = 1'b1;
               alu_op = opcode;
            end else if (is_ifmt) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               alu_op = opcode;
            end else if (is_ldi || is_ld || is_st) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               alu_op = OpAdd;
            end else if (is_br) begin
               PCout = 1'b1;
               Yin   = 1'b1;
            end else begin
               state_d = StT0;
            end
         end
         StT5: begin
            state_d = StT0;
`ifdef MULDIV_EN
            if (is_muldiv) begin
               Zlowout = 1'b1;
               LOin    = 1'b1;
               state_d = StT6;
            end else
`endif
            if (is_rfmt || is_ifmt || is_ldi) begin
               Zlowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end else if (is_ld || is_st) begin
               Zlowout = 1'b1;
               MARin   = 1'b1;
               state_d = StT6;
            end else if (is_br) begin
               Cout    = 1'b1;
               Zin     = 1'b1;
               alu_op  = OpAdd;
               state_d = StT6;
            end
         end
         StT6: begin
            state_d = StT0;
`ifdef MULDIV_EN
            if (is_muldiv) begin
               Zhighout = 1'b1;
               HIin     = 1'b1;
            end else
`endif
            if (is_ld) begin
               Read  = 1'b1;
               MDRin = 1'b1;
               state_d = mem_ready ? StT7 : StT6;
            end else if (is_st) begin
               // Read low steers the bus, not memory, into MDR.
               Gra     = 1'b1;
               Rout    = 1'b1;
               MDRin   = 1'b1;
               state_d = StT7;
            end else if (is_br && con_ff) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
         end
         StT7: begin
            state_d = StT0;
            if (is_ld) begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end else if (is_st) begin
               Write   = 1'b1;
               state_d = mem_ready ? StT0 : StT7;
            end
         end
         StHalt: begin
            run_out = 1'b0;
            state_d = StHalt;
         end
         default: state_d = StT0;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. A reference model expands each instruction into
// the list of per-cycle expected outputs straight from the T-state tables; the bench replays
// that list, randomizing every input the design is supposed to ignore.

module tb_control_sequencer;

   localparam logic [4:0] OpLd   = 5'b00000;
   localparam logic [4:0] OpLdi  = 5'b00001;
   localparam logic [4:0] OpSt   = 5'b00010;
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpMul  = 5'b01111;
   localparam logic [4:0] OpDiv  = 5'b10000;
   localparam logic [4:0] OpBr   = 5'b10011;
   localparam logic [4:0] OpJr   = 5'b10100;
   localparam logic [4:0] OpHalt = 5'b11011;

   // Strobe masks, bit order matches obs_strobes below.
   localparam logic [22:0] MGra      = 23'd1 << 0;
   localparam logic [22:0] MGrb      = 23'd1 << 1;
   localparam logic [22:0] MGrc      = 23'd1 << 2;
   localparam logic [22:0] MRin      = 23'd1 << 3;
   localparam logic [22:0] MRout     = 23'd1 << 4;
   localparam logic [22:0] MBAout    = 23'd1 << 5;
   localparam logic [22:0] MPCout    = 23'd1 << 6;
   localparam logic [22:0] MPCin     = 23'd1 << 7;
   localparam logic [22:0] MIncPC    = 23'd1 << 8;
   localparam logic [22:0] MMARin    = 23'd1 << 9;
   localparam logic [22:0] MMDRin    = 23'd1 << 10;
   localparam logic [22:0] MMDRout   = 23'd1 << 11;
   localparam logic [22:0] MIRin     = 23'd1 << 12;
   localparam logic [22:0] MYin      = 23'd1 << 13;
   localparam logic [22:0] MZin      = 23'd1 << 14;
   localparam logic [22:0] MZlowout  = 23'd1 << 15;
   localparam logic [22:0] MZhighout = 23'd1 << 16;
   localparam logic [22:0] MCout     = 23'd1 << 17;
   localparam logic [22:0] MCONin    = 23'd1 << 18;
   localparam logic [22:0] MHIin     = 23'd1 << 19;
   localparam logic [22:0] MLOin     = 23'd1 << 20;
   localparam logic [22:0] MRead     = 23'd1 << 21;
   localparam logic [22:0] MWrite    = 23'd1 << 22;

   logic clock, reset_n, run_in, con_ff, mem_ready;
   logic [4:0] opcode;
   logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
   logic Yin, Zin, Zlowout, Zhighout, Cout, CONin, HIin, LOin, Read, Write, run_out;
   logic [4:0] alu_op;
   logic [3:0] state;

   control_sequencer dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .run_in   (run_in),
      .opcode   (opcode),
      .con_ff   (con_ff),
      .mem_ready(mem_ready),
      .Gra      (Gra),
      .Grb      (Grb),
      .Grc      (Grc),
      .Rin      (Rin),
      .Rout     (Rout),
      .BAout    (BAout),
      .PCout    (PCout),
      .PCin     (PCin),
      .IncPC    (IncPC),
      .MARin    (MARin),
      .MDRin    (MDRin),
      .MDRout   (MDRout),
      .IRin     (IRin),
      .Yin      (Yin),
      .Zin      (Zin),
      .Zlowout  (Zlowout),
      .Zhighout (Zhighout),
      .Cout     (Cout),
      .CONin    (CONin),
      .HIin     (HIin),
      .LOin     (LOin),
      .Read     (Read),
      .Write    (Write),
      .alu_op   (alu_op),
      .run_out  (run_out),
      .state    (state)
   );

   logic [22:0] obs_strobes;
   logic [32:0] obs;
   assign obs_strobes = {Write, Read, LOin, HIin, CONin, Cout, Zhighout, Zlowout, Zin, Yin, IRin,
                         MDRout, MDRin, MARin, IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb,
                         Gra};
   assign obs = {state, run_out, alu_op, obs_strobes};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [32:0] mk(input int st, input logic ro, input logic [4:0] alu,
                                      input logic [22:0] m);
      return {4'(st), ro, alu, m};
   endfunction

   // Expected cycle list: output word, mem_ready to drive and run_in to drive (-1 = random).
   logic [32:0] exp_q[$];
   int          mr_q[$];
   int          rin_q[$];

   task automatic push(input int st, input logic [22:0] m, input logic [4:0] alu, input int mr,
                       input int rin);
      exp_q.push_back(mk(st, (st == 8) ? 1'b0 : 1'b1, alu, m));
      mr_q.push_back(mr);
      rin_q.push_back(rin);
   endtask

   // A memory wait state: w cycles with mem_ready low, then one with it high.
   task automatic push_wait(input int st, input logic [22:0] m, input int w);
      for (int i = 0; i < w; i++) push(st, m, 5'd0, 0, -1);
      push(st, m, 5'd0, 1, -1);
   endtask

   task automatic build(input logic [4:0] op, input logic con, input int w1, input int w6,
                        input int w7);
      bit rfmt, ifmt, muldiv;
      rfmt = (op >= 5'd3) && (op <= 5'd11);
      ifmt = (op >= 5'd12) && (op <= 5'd14);
`ifdef MULDIV_EN
      muldiv = (op == OpMul) || (op == OpDiv);
`else
      muldiv = 1'b0;
`endif
      push(0, MPCout | MMARin | MIncPC | MZin, OpAdd, -1, 1);
      push_wait(1, MZlowout | MPCin | MRead | MMDRin, w1);
      push(2, MMDRout | MIRin, 5'd0, -1, -1);
      if (rfmt || ifmt) begin
         push(3, MGrb | MRout | MYin, 5'd0, -1, -1);
         push(4, (rfmt ? (MGrc | MRout) : MCout) | MZin, op, -1, -1);
         push(5, MZlowout | MGra | MRin, 5'd0, -1, -1);
      end else if (op == OpLdi || op == OpLd || op == OpSt) begin
         push(3, MGrb | MBAout | MYin, 5'd0, -1, -1);
         push(4, MCout | MZin, OpAdd, -1, -1);
         if (op == OpLdi) begin
            push(5, MZlowout | MGra | MRin, 5'd0, -1, -1);
         end else begin
            push(5, MZlowout | MMARin, 5'd0, -1, -1);
            if (op == OpLd) begin
               push_wait(6, MRead | MMDRin, w6);
               push(7, MMDRout | MGra | MRin, 5'd0, -1, -1);
            end else begin
               push(6, MGra | MRout | MMDRin, 5'd0, -1, -1);
               push_wait(7, MWrite, w7);
            end
         end
      end else if (op == OpBr) begin
         push(3, MGra | MRout | MCONin, 5'd0, -1, -1);
         push(4, MPCout | MYin, 5'd0, -1, -1);
         push(5, MCout | MZin, OpAdd, -1, -1);
         push(6, con ? (MZlowout | MPCin) : 23'd0, 5'd0, -1, -1);
      end else if (op == OpJr) begin
         push(3, MGra | MRout | MPCin, 5'd0, -1, -1);
      end else if (muldiv) begin
         push(3, MGra | MRout | MYin, 5'd0, -1, -1);
         push(4, MGrb | MRout | MZin, op, -1, -1);
         push(5, MZlowout | MLOin, 5'd0, -1, -1);
         push(6, MZhighout | MHIin, 5'd0, -1, -1);
      end else begin
         push(3, 23'd0, 5'd0, -1, -1);  // nop, halt, undefined
      end
   endtask

   // Replay up to max_n queued cycles; inputs driven just after posedge, outputs sampled at
   // negedge.
   task automatic run_queue(input int max_n, input logic [4:0] op, input logic con);
      int n;
      logic [32:0] e;
      int mr, rin;
      n = (exp_q.size() < max_n) ? exp_q.size() : max_n;
      for (int i = 0; i < n; i++) begin
         e   = exp_q.pop_front();
         mr  = mr_q.pop_front();
         rin = rin_q.pop_front();
         opcode    = (e[32:29] < 4'd3) ? 5'($urandom) : op;
         con_ff    = (e[32:29] < 4'd4) ? 1'($urandom) : con;
         mem_ready = (mr < 0) ? 1'($urandom) : 1'(mr);
         run_in    = (rin < 0) ? 1'($urandom) : 1'(rin);
         @(negedge clock);
         check($sformatf("op%05b_c%0d_cyc%0d", op, con, i), 64'(obs), 64'(e));
         @(posedge clock);
         #1;
      end
      exp_q.delete();
      mr_q.delete();
      rin_q.delete();
   endtask

   task automatic do_instr(input logic [4:0] op, input logic con, input int w1, input int w6,
                           input int w7);
      build(op, con, w1, w6, w7);
      run_queue(1000, op, con);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(0, 23'd0, 5'd0, -1, 0);
      run_queue(1000, 5'd0, 1'b0);
   endtask

   initial begin
      logic [4:0] op;
      reset_n   = 1'b0;
      run_in    = 1'b1;
      mem_ready = 1'b0;
      opcode    = 5'd0;
      con_ff    = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", 64'(obs), 64'(mk(0, 1'b1, 5'd0, 23'd0)));
      reset_n = 1'b1;

      // Directed cases.
      do_instr(OpAdd, 1'b0, 0, 0, 0);
      do_instr(OpLd, 1'b0, 0, 3, 0);
      do_instr(OpBr, 1'b0, 0, 0, 0);
      do_instr(OpBr, 1'b1, 0, 0, 0);
      do_instr(OpMul, 1'b0, 0, 0, 0);
      do_instr(OpDiv, 1'b0, 1, 0, 0);
      do_instr(OpJr, 1'b0, 2, 0, 0);
      do_instr(OpSt, 1'b0, 0, 0, 2);
      idle(3);

      // Randomized instruction stream.
      for (int k = 0; k < 200; k++) begin
         do op = 5'($urandom); while (op == OpHalt);
         do_instr(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end

      // Asynchronous reset while st sits in T6.
      build(OpSt, 1'b0, 0, 0, 2);
      run_queue(6, OpSt, 1'b0);
      check("st_in_t6", 64'(state), 64'd6);
      reset_n = 1'b0;
      #1;
      check("st_async_rst", 64'(obs), 64'(mk(0, 1'b1, 5'd0, 23'd0)));
      @(posedge clock);
      #1;
      check("st_rst_held", 64'(obs), 64'(mk(0, 1'b1, 5'd0, 23'd0)));
      run_in  = 1'b1;
      reset_n = 1'b1;
      do_instr(OpAdd, 1'b0, 0, 0, 0);

      // Halt: parked for 20 cycles regardless of inputs, left only by reset.
      build(OpHalt, 1'b0, 1, 0, 0);
      for (int i = 0; i < 20; i++) push(8, 23'd0, 5'd0, -1, -1);
      run_queue(1000, OpHalt, 1'b0);
      run_in  = 1'b0;
      reset_n = 1'b0;
      #1;
      check("halt_rst", 64'(obs), 64'(mk(0, 1'b1, 5'd0, 23'd0)));
      #1;
      reset_n = 1'b1;
      #1;
      check("halt_rst_idle", 64'(obs), 64'(mk(0, 1'b1, 5'd0, 23'd0)));
      do_instr(OpAdd, 1'b0, 0, 0, 0);
      do_instr(OpLdi, 1'b0, 0, 0, 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
